// File: rtl/dvi_pixel_feeder_pkg.sv
// Shared widths and state encoding for the DVI pixel feeder and its frame-reader neighbours.
package dvi_pixel_feeder_pkg;

  localparam int CHUNK_PIX = 256;
  localparam int PIX_W     = 24;
  localparam int CHUNK_W   = CHUNK_PIX * PIX_W;
  localparam int IDX_W     = 8;
  localparam int ASK_CNT_W = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME1 = 2'd1,
    PRIME2 = 2'd2,
    STREAM = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/dvi_pixel_feeder_chunk_slicer.sv
// Holds the current 256-pixel chunk and its read index; emits one registered pixel per request.
module chunk_slicer
  import dvi_pixel_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic               load_valid,
  input  logic [CHUNK_W-1:0] load_data,
  input  logic               req,
  output logic [PIX_W-1:0]   sel,
  output logic               cur_valid,
  output logic               wrap
);

  logic [CHUNK_W-1:0] cur_q, cur_d;
  logic               cur_valid_q, cur_valid_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic [PIX_W-1:0]   sel_q, sel_d;

  // A load in the same cycle as a request still reads the old chunk; the new one starts at index 0.
  always_comb begin
    cur_d       = cur_q;
    cur_valid_d = cur_valid_q;
    pix_idx_d   = pix_idx_q;
    sel_d       = '0;
    if (req) begin
      sel_d     = cur_q[pix_idx_q*PIX_W +: PIX_W];
      pix_idx_d = pix_idx_q + IDX_W'(1);
    end
    if (load) begin
      cur_d       = load_data;
      cur_valid_d = load_valid;
      pix_idx_d   = '0;
    end
    if (clear) begin
      cur_valid_d = 1'b0;
      pix_idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_valid_q <= 1'b0;
      pix_idx_q   <= '0;
      sel_q       <= '0;
    end else begin
      cur_valid_q <= cur_valid_d;
      pix_idx_q   <= pix_idx_d;
      sel_q       <= sel_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
  end

  assign sel       = sel_q;
  assign cur_valid = cur_valid_q;
  assign wrap      = req && (pix_idx_q == IDX_W'(CHUNK_PIX - 1));

endmodule

// File: rtl/dvi_pixel_feeder.sv
// Double-buffered chunk-to-pixel feeder: primes two chunks per frame, then streams one pixel per request.
// Handshake: ask_data is a one-cycle pulse and read_data is captured at the clock edge ending that cycle.
module dvi_pixel_feeder
  import dvi_pixel_feeder_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int PRIME_WAIT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ram_init,
  input  logic               frame_start,
  input  logic               pix_req,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_valid,
  output logic               underflow,
  input  logic [CHUNK_W-1:0] read_data,
  output logic               ask_data,
  output logic               new_frame,
  output logic [1:0]         dbg_state
);

  localparam int CHUNKS = H_ACTIVE * V_ACTIVE / CHUNK_PIX;
  localparam logic [ASK_CNT_W-1:0] CHUNKS_C = ASK_CNT_W'(CHUNKS);
  localparam int WAIT_W = $clog2(PRIME_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PRIME_WAIT);

  feeder_state_e        state_q, state_d;
  logic [ASK_CNT_W-1:0] ask_cnt_q, ask_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 ask_data_q, ask_data_d;
  logic                 ask_to_nxt_q, ask_to_nxt_d;
  logic                 new_frame_q, new_frame_d;
  logic                 underflow_q, underflow_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [CHUNK_W-1:0]   nxt_q, nxt_d;
  logic                 nxt_valid_q, nxt_valid_d;

  logic               sl_clear, sl_load, sl_load_valid, sl_req;
  logic [CHUNK_W-1:0] sl_load_data;
  logic [PIX_W-1:0]   sl_sel;
  logic               sl_cur_valid, sl_wrap;
  logic               fs_accept;

  assign fs_accept = frame_start && ram_init;

  always_comb begin
    state_d       = state_q;
    ask_cnt_d     = ask_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    ask_data_d    = 1'b0;
    ask_to_nxt_d  = ask_to_nxt_q;
    new_frame_d   = 1'b0;
    underflow_d   = underflow_q;
    pix_valid_d   = 1'b0;
    nxt_d         = nxt_q;
    nxt_valid_d   = nxt_valid_q;
    sl_clear      = 1'b0;
    sl_load       = 1'b0;
    sl_load_valid = nxt_valid_q;
    sl_load_data  = nxt_q;
    sl_req        = 1'b0;

    // Land the chunk requested last cycle in whichever buffer the request targeted.
    if (ask_data_q) begin
      if (ask_to_nxt_q) begin
        nxt_d       = read_data;
        nxt_valid_d = 1'b1;
      end else begin
        sl_load       = 1'b1;
        sl_load_valid = 1'b1;
        sl_load_data  = read_data;
      end
    end

    case (state_q)
      PRIME1: begin
        if (wait_cnt_q == WAIT_LAST) begin
          ask_data_d   = 1'b1;
          ask_to_nxt_d = 1'b0;
          ask_cnt_d    = ask_cnt_q + ASK_CNT_W'(1);
          wait_cnt_d   = '0;
          state_d      = PRIME2;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      PRIME2: begin
        if (wait_cnt_q == WAIT_LAST) begin
          ask_data_d   = 1'b1;
          ask_to_nxt_d = 1'b1;
          ask_cnt_d    = ask_cnt_q + ASK_CNT_W'(1);
          wait_cnt_d   = '0;
          state_d      = STREAM;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      STREAM: begin
        if (pix_req && sl_cur_valid) begin
          sl_req      = 1'b1;
          pix_valid_d = 1'b1;
          if (sl_wrap) begin
            sl_load       = 1'b1;
            sl_load_valid = nxt_valid_q;
            sl_load_data  = nxt_q;
            nxt_valid_d   = 1'b0;
            if (ask_cnt_q < CHUNKS_C) begin
              ask_data_d   = 1'b1;
              ask_to_nxt_d = 1'b1;
              ask_cnt_d    = ask_cnt_q + ASK_CNT_W'(1);
            end else if (!nxt_valid_q) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: ;
    endcase

    if (pix_req && !(state_q == STREAM && sl_cur_valid)) begin
      pix_valid_d = 1'b1;
      underflow_d = 1'b1;
    end

    // An accepted frame start wins over everything, including a request in the same cycle.
    if (fs_accept) begin
      state_d     = PRIME1;
      new_frame_d = 1'b1;
      ask_cnt_d   = '0;
      wait_cnt_d  = '0;
      ask_data_d  = 1'b0;
      nxt_valid_d = 1'b0;
      underflow_d = 1'b0;
      pix_valid_d = 1'b0;
      sl_clear    = 1'b1;
      sl_load     = 1'b0;
      sl_req      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ask_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      ask_data_q   <= 1'b0;
      ask_to_nxt_q <= 1'b0;
      new_frame_q  <= 1'b0;
      underflow_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
      nxt_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ask_cnt_q    <= ask_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      ask_data_q   <= ask_data_d;
      ask_to_nxt_q <= ask_to_nxt_d;
      new_frame_q  <= new_frame_d;
      underflow_q  <= underflow_d;
      pix_valid_q  <= pix_valid_d;
      nxt_valid_q  <= nxt_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    nxt_q <= nxt_d;
  end

  chunk_slicer u_slicer (
    .clk        (clk),
    .reset      (reset),
    .clear      (sl_clear),
    .load       (sl_load),
    .load_valid (sl_load_valid),
    .load_data  (sl_load_data),
    .req        (sl_req),
    .sel        (sl_sel),
    .cur_valid  (sl_cur_valid),
    .wrap       (sl_wrap)
  );

  assign pix_data  = sl_sel;
  assign pix_valid = pix_valid_q;
  assign underflow = underflow_q;
  assign ask_data  = ask_data_q;
  assign new_frame = new_frame_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dvi_pixel_feeder.sv
// Directed bench for dvi_pixel_feeder: priming timing, streaming, full frame, underflow, resync, reset.
module tb_dvi_pixel_feeder;
  import dvi_pixel_feeder_pkg::*;

  logic               clk = 1'b0;
  logic               reset, ram_init, frame_start, pix_req;
  logic [PIX_W-1:0]   pix_data;
  logic               pix_valid, underflow, ask_data, new_frame;
  logic [CHUNK_W-1:0] read_data;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int chunk_no = 0;
  int ask_consec = 0;
  logic ask_pend = 1'b0;
  logic ask_last = 1'b0;
  int ask_cyc[$];
  logic [PIX_W-1:0] exp_q[$];

  dvi_pixel_feeder #(.H_ACTIVE(512), .V_ACTIVE(2), .PRIME_WAIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ram_init    (ram_init),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underflow   (underflow),
    .read_data   (read_data),
    .ask_data    (ask_data),
    .new_frame   (new_frame),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [CHUNK_W-1:0] make_chunk(input int k);
    logic [CHUNK_W-1:0] c;
    for (int i = 0; i < CHUNK_PIX; i++) c[i*PIX_W +: PIX_W] = {8'(k), 8'(i), 8'hA5};
    return c;
  endfunction

  function automatic logic [PIX_W-1:0] pix_of(input int k, input int i);
    return {8'(k), 8'(i), 8'hA5};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: sample just after the edge, play the frame reader, and score any pixel.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ask_pend) begin
      chunk_no++;
      read_data = make_chunk(chunk_no);
      ask_pend  = 1'b0;
    end
    if (new_frame) begin
      chunk_no  = 0;
      read_data = make_chunk(0);
    end
    if (ask_data) begin
      ask_pend = 1'b1;
      ask_cyc.push_back(cyc);
      if (ask_last) ask_consec++;
    end
    ask_last = ask_data;
    if (pix_valid) begin
      if (exp_q.size() == 0) check("pix_extra", 32'(exp_q.size()), 32'd1);
      else check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    reset = 1'b1; ram_init = 1'b0; frame_start = 1'b0; pix_req = 1'b0;
    read_data = make_chunk(0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_ask", 32'(ask_data), 0);
    check("rst_new_frame", 32'(new_frame), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Priming: new_frame at 1, asks at 6 and 11.
    ram_init = 1'b1; frame_start = 1'b1; cyc = 0; ask_cyc.delete();
    tick();
    frame_start = 1'b0;
    check("prime_new_frame", 32'(new_frame), 1);
    tick();
    check("prime_new_frame_pulse", 32'(new_frame), 0);
    while (cyc < 12) tick();
    check("prime_no_pix", 32'(pix_valid), 0);
    check("prime_ask_n", 32'(ask_cyc.size()), 2);
    if (ask_cyc.size() >= 2) begin
      check("prime_ask0", 32'(ask_cyc[0]), 6);
      check("prime_ask1", 32'(ask_cyc[1]), 11);
    end

    // Full frame of 4 chunks, back-to-back requests.
    for (int j = 0; j < 1024; j++) begin
      pix_req = 1'b1;
      exp_q.push_back(pix_of(j / 256, j % 256));
      tick();
      check("stream_valid", 32'(pix_valid), 1);
      if (j == 511) check("stream_state", 32'(dbg_state), 32'(STREAM));
    end
    pix_req = 1'b0;
    check("frame_state_idle", 32'(dbg_state), 32'(IDLE));
    check("frame_underflow", 32'(underflow), 0);
    check("frame_ask_n", 32'(ask_cyc.size()), 4);
    if (ask_cyc.size() >= 4) begin
      check("refill_ask0", 32'(ask_cyc[2]), 268);
      check("refill_ask1", 32'(ask_cyc[3]), 524);
    end
    tick();
    check("frame_drained", 32'(exp_q.size()), 0);

    // Underflow during PRIME1, sticky until the next frame start.
    frame_start = 1'b1; cyc = 0; ask_cyc.delete();
    tick();
    frame_start = 1'b0;
    check("f2_new_frame", 32'(new_frame), 1);
    pix_req = 1'b1;
    exp_q.push_back('0);
    tick();
    pix_req = 1'b0;
    check("uf_valid", 32'(pix_valid), 1);
    check("uf_flag", 32'(underflow), 1);
    check("uf_state", 32'(dbg_state), 32'(PRIME1));
    while (cyc < 12) tick();
    check("uf_sticky", 32'(underflow), 1);
    if (ask_cyc.size() >= 2) check("f2_ask1", 32'(ask_cyc[1]), 11);
    else check("f2_ask_n", 32'(ask_cyc.size()), 2);

    // Resync mid-chunk at pix_idx 100; the request in the frame_start cycle is ignored.
    for (int j = 0; j < 100; j++) begin
      pix_req = 1'b1;
      exp_q.push_back(pix_of(0, j));
      tick();
    end
    frame_start = 1'b1; cyc = 0; ask_cyc.delete();
    tick();
    frame_start = 1'b0; pix_req = 1'b0;
    check("resync_new_frame", 32'(new_frame), 1);
    check("resync_no_pix", 32'(pix_valid), 0);
    check("resync_uf_clear", 32'(underflow), 0);
    while (cyc < 12) tick();
    check("resync_ask_n", 32'(ask_cyc.size()), 2);
    if (ask_cyc.size() >= 2) begin
      check("resync_ask0", 32'(ask_cyc[0]), 6);
      check("resync_ask1", 32'(ask_cyc[1]), 11);
    end
    pix_req = 1'b1;
    exp_q.push_back(pix_of(0, 0));
    tick();
    pix_req = 1'b0;
    check("resync_first_valid", 32'(pix_valid), 1);

    // frame_start with ram_init low is ignored.
    ram_init = 1'b0; frame_start = 1'b1; ask_cyc.delete();
    tick();
    frame_start = 1'b0;
    check("noinit_new_frame", 32'(new_frame), 0);
    repeat (10) tick();
    check("noinit_ask_n", 32'(ask_cyc.size()), 0);
    check("noinit_state", 32'(dbg_state), 32'(STREAM));

    // Reset mid-STREAM, then a request in IDLE underflows.
    reset = 1'b1; pix_req = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_pix_valid", 32'(pix_valid), 0);
    check("mrst_pix_data", 32'(pix_data), 0);
    check("mrst_ask", 32'(ask_data), 0);
    check("mrst_underflow", 32'(underflow), 0);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.push_back('0);
    tick();
    pix_req = 1'b0;
    check("idle_uf_flag", 32'(underflow), 1);
    tick();
    check("final_drained", 32'(exp_q.size()), 0);
    check("ask_never_consecutive", 32'(ask_consec), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
